svn_seg_scan: RTL and testbench

//  Time-multiplexed scan controller for a multi-digit 7-segment display.

---
 rtl/svn_seg_scan.sv | 113 +++++++++++
 tb/tb_svn_seg_scan.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/svn_seg_scan.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment display driving a shared svn_seg decoder.
// Digit data is double-buffered and only swapped on the last cycle of a full scan.
module svn_seg_scan #(
  parameter int NDIG      = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [4*NDIG-1:0] DATA,
  input  logic              LOAD,
  input  logic              LZ_EN,
  output logic              ACK,
  output logic              FRAME,
  output logic [3:0]        D,
  output logic [NDIG-1:0]   AN
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);

  logic [CW-1:0]     cnt_r;
  logic [IW-1:0]     idx_r;
  logic [4*NDIG-1:0] shadow_r;

  logic [CW-1:0]     cnt_nxt_s;
  logic [IW-1:0]     idx_nxt_s;
  logic              frame_nxt_s;
  logic [NDIG-1:0]   supp_vec_s;
  logic              supp_s;
  logic [3:0]        nib_s;
  logic [3:0]        d_nxt_s;
  logic [NDIG-1:0]   an_nxt_s;
  logic              all_zero_s;

  // Slot counter and digit index for the cycle that starts at the next edge
  always_comb begin
    cnt_nxt_s = cnt_r;
    idx_nxt_s = idx_r;
    if (cnt_r == CW'(DIV - 1)) begin
      cnt_nxt_s = {CW{1'b0}};
      if (idx_r == IW'(NDIG - 1)) begin
        idx_nxt_s = {IW{1'b0}};
      end else begin
        idx_nxt_s = idx_r + IW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
      idx_nxt_s = idx_r;
    end
    frame_nxt_s = (idx_nxt_s == IW'(NDIG - 1)) && (cnt_nxt_s == CW'(DIV - 1));
  end

  // Leading-zero map: digit i is blanked when it and every digit above it are zero
  always_comb begin
    supp_vec_s = {NDIG{1'b0}};
    all_zero_s = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      all_zero_s    = all_zero_s && (shadow_r[4*i +: 4] == 4'h0);
      supp_vec_s[i] = LZ_EN && all_zero_s;
    end
  end

  // Digit code and anode pattern for the upcoming cycle
  always_comb begin
    nib_s = 4'hF;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_nxt_s == IW'(i)) begin
        nib_s = shadow_r[4*i +: 4];
      end else begin
        nib_s = nib_s;
      end
    end
    supp_s = supp_vec_s[idx_nxt_s];
    if (supp_s) begin
      d_nxt_s = 4'hF;
    end else begin
      d_nxt_s = nib_s;
    end
    an_nxt_s = {NDIG{1'b1}};
    if ((cnt_nxt_s >= CW'(BLANK_CYC)) && !supp_s) begin
      an_nxt_s[idx_nxt_s] = 1'b0;
    end else begin
      an_nxt_s = {NDIG{1'b1}};
    end
  end

  // State and registered outputs; LOAD/DATA are taken at the edge that opens the FRAME cycle
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_r    <= {CW{1'b0}};
      idx_r    <= {IW{1'b0}};
      shadow_r <= {(4*NDIG){1'b0}};
      D        <= 4'hF;
      AN       <= {NDIG{1'b1}};
      ACK      <= 1'b0;
      FRAME    <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      idx_r <= idx_nxt_s;
      D     <= d_nxt_s;
      AN    <= an_nxt_s;
      FRAME <= frame_nxt_s;
      ACK   <= frame_nxt_s && LOAD;
      if (frame_nxt_s && LOAD) begin
        shadow_r <= DATA;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

endmodule

// File: tb/tb_svn_seg_scan.sv
// Scoreboard bench for svn_seg_scan (NDIG=4, DIV=8, BLANK_CYC=2): a cycle-index model pushes
// expected outputs at each edge, a negedge checker pops and compares them.
module tb_svn_seg_scan;

  localparam int NDIG = 4;
  localparam int DIV  = 8;
  localparam int BLK  = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        load;
  logic        lz_en;
  logic        ack;
  logic        frame;
  logic [3:0]  d;
  logic [3:0]  an;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] an;
    logic       ack;
    logic       frame;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e_m;
  int          k_m;
  int          cnt_m;
  int          slot_m;
  logic        supp_m;
  logic [15:0] sh_m;
  int          n_chk;
  int          n_fail;

  svn_seg_scan #(.NDIG(NDIG), .DIV(DIV), .BLANK_CYC(BLK)) dut (
    .CLK(clk), .RST_N(rst_n), .DATA(data), .LOAD(load), .LZ_EN(lz_en),
    .ACK(ack), .FRAME(frame), .D(d), .AN(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h exp=%h t=%0t", tag, k_m, got, exp, $time);
    end
  endtask

  // Reference model: k_m counts cycles since the last reset edge
  always @(posedge clk) begin
    if (!rst_n) begin
      k_m  = 0;
      sh_m = 16'h0000;
      e_m  = '{d: 4'hF, an: 4'hF, ack: 1'b0, frame: 1'b0};
    end else begin
      k_m++;
      cnt_m     = k_m % DIV;
      slot_m    = (k_m / DIV) % NDIG;
      e_m.frame = (slot_m == NDIG - 1) && (cnt_m == DIV - 1);
      e_m.ack   = e_m.frame && load;
      supp_m    = lz_en && (slot_m > 0) && ((sh_m >> (4 * slot_m)) == 16'h0000);
      e_m.d     = supp_m ? 4'hF : 4'((sh_m >> (4 * slot_m)) & 16'h000F);
      e_m.an    = (cnt_m < BLK || supp_m) ? 4'hF : ~(4'b0001 << slot_m);
      if (e_m.ack) sh_m = data;
    end
    sb_q.push_back(e_m);
  end

  // Compare each DUT output against the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("d", 32'(d), 32'(e.d));
      check("an", 32'(an), 32'(e.an));
      check("ack", 32'(ack), 32'(e.ack));
      check("frame", 32'(frame), 32'(e.frame));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    logic seen;
    seen = 1'b0;
    data = w;
    load = 1'b1;
    for (int i = 0; i < 80; i++) begin
      cycles(1);
      if (ack) begin
        seen = 1'b1;
        break;
      end
    end
    load = 1'b0;
    check("ack_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    data   = 16'h0000;
    load   = 1'b0;
    lz_en  = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    // first frame blank-then-lit with zero shadow, then load 1234 and show it
    cycles(30);
    load_word(16'h1234);
    cycles(40);
    lz_en = 1'b1;
    load_word(16'h0050);
    cycles(40);
    load_word(16'h0000);
    cycles(40);
    load_word(16'h0302);
    cycles(40);
    lz_en = 1'b0;
    load_word(16'h1111);
    data = 16'h9999;
    cycles(64);
    load_word(16'h9999);
    cycles(40);
    // reset in slot 2 at cnt 5
    for (int i = 0; i < 64; i++) begin
      if (k_m % (NDIG * DIV) == 2 * DIV + 5) break;
      cycles(1);
    end
    check("rst_point", 32'(k_m % (NDIG * DIV)), 32'(2 * DIV + 5));
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(40);
    lz_en = 1'b1;
    load_word(16'hA000);
    cycles(40);
    load = 1'b1;
    data = 16'h0807;
    cycles(70);
    load = 1'b0;
    cycles(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
